// File: rtl/contador_modular.sv
// Modulo-N clock-field counter. RUN advances on tick_in and emits a carry on wrap.
// SET adjusts the field with edge-detected, auto-repeating UP/DOWN buttons.
module contador_modular #(
  parameter int MODULUS      = 24,
  parameter int INIT_VALUE   = 15,
  parameter int WIDTH        = 7,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             set_mode,
  input  logic             UP,
  input  logic             DOWN,
  output logic             carry_out,
  output logic [WIDTH-1:0] value,
  output logic [6:0]       seg_units,
  output logic [6:0]       seg_tens
);
  // state   | meaning
  // IDLE    | no button owned; a fresh lone press steps once
  // HELD_UP | UP held alone after a press; repeat counter running
  // HELD_DN | DOWN held alone after a press; repeat counter running
  typedef enum logic [1:0] {IDLE, HELD_UP, HELD_DN} btn_state_t;

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_VALUE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [31:0]      DELAY_TC = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]      RATE_TC  = 32'(REPEAT_RATE - 1);
  localparam logic [3:0]       INIT_U   = 4'(INIT_VALUE % 10);
  localparam logic [3:0]       INIT_T   = 4'(INIT_VALUE / 10);

  btn_state_t       state;
  logic [31:0]      rpt_cnt;
  logic             repeating;
  logic             up_held;
  logic             dn_held;
  logic [WIDTH-1:0] val_inc;
  logic [WIDTH-1:0] val_dec;
  logic             up_press;
  logic             dn_press;
  logic             rpt_fire;
  logic [7:0]       v8;
  logic [3:0]       dig_units;
  logic [3:0]       dig_tens;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7f;
    endcase
  endfunction

  always_comb begin
    val_inc   = (value == MAX_VAL) ? '0 : value + ONE;
    val_dec   = (value == '0) ? MAX_VAL : value - ONE;
    // a press only counts on the button's rising edge and with the other one idle
    up_press  = UP & ~up_held & ~DOWN;
    dn_press  = DOWN & ~dn_held & ~UP;
    rpt_fire  = (rpt_cnt == (repeating ? RATE_TC : DELAY_TC));
    v8        = 8'(value);
    dig_units = 4'(v8 % 8'd10);
    dig_tens  = 4'(v8 / 8'd10);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value     <= INIT_VAL;
      carry_out <= 1'b0;
      state     <= IDLE;
      rpt_cnt   <= '0;
      repeating <= 1'b0;
      up_held   <= 1'b0;
      dn_held   <= 1'b0;
      seg_units <= seg_code(INIT_U);
      seg_tens  <= seg_code(INIT_T);
    end else begin
      up_held   <= UP;
      dn_held   <= DOWN;
      seg_units <= seg_code(dig_units);
      seg_tens  <= seg_code(dig_tens);
      if (!set_mode) begin
        carry_out <= tick_in && (value == MAX_VAL);
        if (tick_in) value <= val_inc;
        state     <= IDLE;
        rpt_cnt   <= '0;
        repeating <= 1'b0;
      end else begin
        carry_out <= 1'b0;
        case (state)
          IDLE: begin
            rpt_cnt   <= '0;
            repeating <= 1'b0;
            if (up_press) begin
              value <= val_inc;
              state <= HELD_UP;
            end else if (dn_press) begin
              value <= val_dec;
              state <= HELD_DN;
            end
          end
          HELD_UP: begin
            if (UP && !DOWN) begin
              if (rpt_fire) begin
                value     <= val_inc;
                rpt_cnt   <= '0;
                repeating <= 1'b1;
              end else begin
                rpt_cnt <= rpt_cnt + 32'd1;
              end
            end else begin
              state     <= IDLE;
              rpt_cnt   <= '0;
              repeating <= 1'b0;
            end
          end
          HELD_DN: begin
            if (DOWN && !UP) begin
              if (rpt_fire) begin
                value     <= val_dec;
                rpt_cnt   <= '0;
                repeating <= 1'b1;
              end else begin
                rpt_cnt <= rpt_cnt + 32'd1;
              end
            end else begin
              state     <= IDLE;
              rpt_cnt   <= '0;
              repeating <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            rpt_cnt   <= '0;
            repeating <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
